// File: rtl/coco3_clk_pkg.sv
// -----------------------------------------------------------------------------
// coco3_clk_pkg
// Shared definitions for the CoCo3 clock/reset sequencing logic.
//   - FSM state codes for the lock/reset sequencer
//   - Divider and CPU phase period constants
//   - Small helpers that turn the active speed into phase boundaries
// -----------------------------------------------------------------------------
package coco3_clk_pkg;

    // Sequencer states (plain constants so older tools and ports can share them)
    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABLE    = 2'd1;
    localparam logic [1:0] PRST      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    // CPU E/Q period in clk cycles for slow (0.895 MHz) and fast (1.79 MHz) mode
    localparam int SLOW_PERIOD = 64;
    localparam int FAST_PERIOD = 32;

    // Clock-enable divide ratios from the 57.27 MHz clock
    localparam int DIV14  = 4;
    localparam int DIV358 = 16;

    // Last phase value of a period at the given speed
    function automatic logic [5:0] period_last(input logic fast);
        if (fast) begin
            return 6'(FAST_PERIOD - 1);
        end else begin
            return 6'(SLOW_PERIOD - 1);
        end
    endfunction

    // Quarter period at the given speed
    function automatic logic [5:0] quarter(input logic fast);
        if (fast) begin
            return 6'(FAST_PERIOD / 4);
        end else begin
            return 6'(SLOW_PERIOD / 4);
        end
    endfunction

endpackage

// File: rtl/cdc_sync2.sv
// -----------------------------------------------------------------------------
// cdc_sync2
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears both stages
//   d_i  - asynchronous input level
//   q_o  - synchronized level, two clk edges of latency
// -----------------------------------------------------------------------------
module cdc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronization of d_i into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_clken_sequencer.sv
// -----------------------------------------------------------------------------
// pll_clken_sequencer
// Waits for a stable PLL lock, releases the peripheral reset and then the CPU
// reset, and produces the single-cycle clock enables and the E/Q phase levels
// used by the CoCo3 core. Loss of lock drops everything back into reset.
// Ports:
//   clk          - 57.272727 MHz system clock
//   rst          - synchronous active-high reset
//   pll_locked   - PLL lock flag, asynchronous to clk
//   turbo        - requested CPU speed (1 = 1.79 MHz, 0 = 0.895 MHz)
//   periph_rst   - active-high peripheral reset
//   cpu_rst      - active-high CPU reset
//   en_14m       - enable pulse every 4 clk
//   en_3m58      - enable pulse every 16 clk, coincident with en_14m
//   cpu_e/cpu_q  - E and Q phase levels (Q leads E by a quarter period)
//   cpu_e_rise   - pulse coincident with cpu_e rising
//   cpu_e_fall   - pulse coincident with cpu_e falling
//   turbo_active - speed currently in effect
// -----------------------------------------------------------------------------
module pll_clken_sequencer #(
    parameter int LOCK_CYCLES = 1024,
    parameter int RST_GAP     = 256,
    parameter int CNT_W       = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic turbo,
    output logic periph_rst,
    output logic cpu_rst,
    output logic en_14m,
    output logic en_3m58,
    output logic cpu_e,
    output logic cpu_q,
    output logic cpu_e_rise,
    output logic cpu_e_fall,
    output logic turbo_active
);

    import coco3_clk_pkg::*;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(RST_GAP - 1);
    localparam logic [3:0]       MASK14    = 4'(DIV14 - 1);
    localparam logic [3:0]       LAST358   = 4'(DIV358 - 1);

    logic             lock_s;
    logic [1:0]       state_q,        state_d;
    logic [CNT_W-1:0] cnt_q,          cnt_d;
    logic [3:0]       div_q,          div_d;
    logic [5:0]       ph_q,           ph_d;
    logic             turbo_active_q, turbo_active_d;

    logic periph_rst_q, periph_rst_d;
    logic cpu_rst_q,    cpu_rst_d;
    logic en_14m_q,     en_14m_d;
    logic en_3m58_q,    en_3m58_d;
    logic cpu_e_q,      cpu_e_d;
    logic cpu_q_q,      cpu_q_d;
    logic cpu_e_rise_q, cpu_e_rise_d;
    logic cpu_e_fall_q, cpu_e_fall_d;

    logic       run_d_s;
    logic       clk_active_d_s;
    logic       wrap_s;
    logic [5:0] qt_s;
    logic [5:0] half_s;
    logic [5:0] three_qt_s;

    cdc_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lock_s)
    );

    // Lock/reset sequencer: next state and shared counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = STABLE;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = PRST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRST: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    assign run_d_s        = (state_d == RUN);
    assign clk_active_d_s = (state_d == PRST) || (state_d == RUN);
    // The current period ends on this cycle; the only point a speed change is taken
    assign wrap_s         = (state_q == RUN) && (ph_q == period_last(turbo_active_q));

    // Enable divider, CPU phase counter and speed latch
    always_comb begin
        if (!clk_active_d_s) begin
            div_d = 4'd0;
        end else if (state_q != PRST && state_q != RUN) begin
            div_d = 4'd0;
        end else begin
            div_d = div_q + 4'd1;
        end

        if (!run_d_s || state_q != RUN || wrap_s) begin
            ph_d = 6'd0;
        end else begin
            ph_d = ph_q + 6'd1;
        end

        // Lock loss clears run_d_s, so it wins over a pending speed change
        if (run_d_s && wrap_s) begin
            turbo_active_d = turbo;
        end else begin
            turbo_active_d = turbo_active_q;
        end
    end

    // Phase boundaries follow the speed of the period that is about to run
    assign qt_s       = quarter(turbo_active_d);
    assign half_s     = qt_s + qt_s;
    assign three_qt_s = half_s + qt_s;

    // Output values derived from next state so they change with the state
    always_comb begin
        periph_rst_d = !clk_active_d_s;
        cpu_rst_d    = !run_d_s;
        en_14m_d     = clk_active_d_s && ((div_d & MASK14) == MASK14);
        en_3m58_d    = clk_active_d_s && (div_d == LAST358);
        cpu_q_d      = run_d_s && (ph_d < half_s);
        cpu_e_d      = run_d_s && (ph_d >= qt_s) && (ph_d < three_qt_s);
        cpu_e_rise_d = run_d_s && (ph_d == qt_s);
        cpu_e_fall_d = run_d_s && (ph_d == three_qt_s);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            div_q          <= 4'd0;
            ph_q           <= 6'd0;
            turbo_active_q <= 1'b0;
            periph_rst_q   <= 1'b1;
            cpu_rst_q      <= 1'b1;
            en_14m_q       <= 1'b0;
            en_3m58_q      <= 1'b0;
            cpu_e_q        <= 1'b0;
            cpu_q_q        <= 1'b0;
            cpu_e_rise_q   <= 1'b0;
            cpu_e_fall_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            div_q          <= div_d;
            ph_q           <= ph_d;
            turbo_active_q <= turbo_active_d;
            periph_rst_q   <= periph_rst_d;
            cpu_rst_q      <= cpu_rst_d;
            en_14m_q       <= en_14m_d;
            en_3m58_q      <= en_3m58_d;
            cpu_e_q        <= cpu_e_d;
            cpu_q_q        <= cpu_q_d;
            cpu_e_rise_q   <= cpu_e_rise_d;
            cpu_e_fall_q   <= cpu_e_fall_d;
        end
    end

    assign periph_rst   = periph_rst_q;
    assign cpu_rst      = cpu_rst_q;
    assign en_14m       = en_14m_q;
    assign en_3m58      = en_3m58_q;
    assign cpu_e        = cpu_e_q;
    assign cpu_q        = cpu_q_q;
    assign cpu_e_rise   = cpu_e_rise_q;
    assign cpu_e_fall   = cpu_e_fall_q;
    assign turbo_active = turbo_active_q;

endmodule

// File: tb/tb_pll_clken_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_clken_sequencer
// Bench for pll_clken_sequencer with LOCK_CYCLES=16, RST_GAP=8. A model tracks
// the length of the current synchronized-lock run and derives every output
// from it; directed scenarios pin the timing with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_pll_clken_sequencer;

    localparam int LC = 16;
    localparam int RG = 8;

    localparam int S_PRST  = 0;
    localparam int S_CRST  = 1;
    localparam int S_E14   = 2;
    localparam int S_E358  = 3;
    localparam int S_Q     = 4;
    localparam int S_RISE  = 5;
    localparam int S_TACT  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;
    logic turbo = 1'b0;
    logic periph_rst, cpu_rst, en_14m, en_3m58, cpu_e, cpu_q;
    logic cpu_e_rise, cpu_e_fall, turbo_active;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    logic cmp_en = 1'b0;

    pll_clken_sequencer #(.LOCK_CYCLES(LC), .RST_GAP(RG), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .turbo        (turbo),
        .periph_rst   (periph_rst),
        .cpu_rst      (cpu_rst),
        .en_14m       (en_14m),
        .en_3m58      (en_3m58),
        .cpu_e        (cpu_e),
        .cpu_q        (cpu_q),
        .cpu_e_rise   (cpu_e_rise),
        .cpu_e_fall   (cpu_e_fall),
        .turbo_active (turbo_active)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    // r = number of consecutive edges the design has seen synchronized lock.
    int   r = 0;
    logic samp_a = 1'b0, samp_b = 1'b0;
    logic m_tact = 1'b0;
    int   pstart = 0, plen = 64, m_ph = 0, u = 0, t = 0, qt = 16;
    logic m_run = 1'b0;
    logic m_prst = 1'b1, m_crst = 1'b1, m_e14 = 1'b0, m_e358 = 1'b0;
    logic m_e = 1'b0, m_q = 1'b0, m_rise = 1'b0, m_fall = 1'b0;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (rst) begin
            r = 0; samp_a = 1'b0; samp_b = 1'b0; m_tact = 1'b0;
            pstart = 0; plen = 64; m_ph = 0;
        end else begin
            r = samp_b ? r + 1 : 0;
            samp_b = samp_a;
            samp_a = pll_locked;
            if (r > LC + RG) begin
                u = r - (LC + RG + 1);
                if (u == 0) begin
                    pstart = 0;
                    plen = m_tact ? 32 : 64;
                end else if (u - pstart == plen) begin
                    m_tact = turbo;
                    pstart = u;
                    plen = m_tact ? 32 : 64;
                end
                m_ph = u - pstart;
            end
        end
        m_prst = (r <= LC);
        m_crst = (r <= LC + RG);
        t = r - (LC + 1);
        m_e14 = (r > LC) && (t % 4 == 3);
        m_e358 = (r > LC) && (t % 16 == 15);
        m_run = (r > LC + RG);
        qt = plen / 4;
        m_q = m_run && (m_ph < 2 * qt);
        m_e = m_run && (m_ph >= qt) && (m_ph < 3 * qt);
        m_rise = m_run && (m_ph == qt);
        m_fall = m_run && (m_ph == 3 * qt);
    end

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s edge=%0d actual=%b required=%b", nm, edge_n, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk_bit("periph_rst", periph_rst, m_prst);
            chk_bit("cpu_rst", cpu_rst, m_crst);
            chk_bit("en_14m", en_14m, m_e14);
            chk_bit("en_3m58", en_3m58, m_e358);
            chk_bit("cpu_e", cpu_e, m_e);
            chk_bit("cpu_q", cpu_q, m_q);
            chk_bit("cpu_e_rise", cpu_e_rise, m_rise);
            chk_bit("cpu_e_fall", cpu_e_fall, m_fall);
            chk_bit("turbo_active", turbo_active, m_tact);
        end
    end

    function automatic logic get_sig(input int sel);
        case (sel)
            S_PRST:  return periph_rst;
            S_CRST:  return cpu_rst;
            S_E14:   return en_14m;
            S_E358:  return en_3m58;
            S_Q:     return cpu_q;
            S_RISE:  return cpu_e_rise;
            S_TACT:  return turbo_active;
            default: return 1'b0;
        endcase
    endfunction

    // Wait (bounded) for a signal to reach a value; returns the edge index it changed on
    task automatic wait_sig(input int sel, input logic val, input int budget,
                            input string nm, output int e);
        e = -1;
        for (int i = 0; i < budget && e < 0; i++) begin
            @(negedge clk);
            if (get_sig(sel) === val) e = edge_n;
        end
        if (e < 0) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s timeout actual=none required=%b", nm, val);
        end
    endtask

    task automatic wait_ph(input int ph, input int budget, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (m_run && m_ph == ph) hit = 1'b1;
        end
        if (!hit) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s timeout actual=none required=ph%0d", nm, ph);
        end
    endtask

    int e_lock, e_p, e_c, e1, e2, e3, ea, eb, e_t;

    initial begin
        rst = 1'b1; pll_locked = 1'b0; turbo = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        // reset state pinned literally
        chk_bit("rst_periph_rst", periph_rst, 1'b1);
        chk_bit("rst_cpu_rst", cpu_rst, 1'b1);
        chk_bit("rst_en_14m", en_14m, 1'b0);
        chk_bit("rst_cpu_q", cpu_q, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // lock glitch of 5 cycles never leaves STABLE
        pll_locked = 1'b1;
        repeat (5) @(negedge clk);
        pll_locked = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk_bit("glitch_periph_rst", periph_rst, 1'b1);
            chk_bit("glitch_cpu_rst", cpu_rst, 1'b1);
        end

        // full lock sequence
        pll_locked = 1'b1;
        e_lock = edge_n + 1;
        wait_sig(S_PRST, 1'b0, 100, "prst_fall", e_p);
        chk_int("prst_fall_delay", e_p - e_lock, LC + 2);
        wait_sig(S_CRST, 1'b0, 100, "crst_fall", e_c);
        chk_int("crst_gap", e_c - e_p, RG);
        chk_bit("run_entry_cpu_q", cpu_q, 1'b1);
        chk_bit("run_entry_cpu_e", cpu_e, 1'b0);

        // slow speed timing
        wait_sig(S_RISE, 1'b1, 200, "rise1", e1);
        wait_sig(S_RISE, 1'b1, 200, "rise2", e2);
        chk_int("slow_rise_interval", e2 - e1, 64);
        wait_sig(S_Q, 1'b0, 200, "q_fall", ea);
        wait_sig(S_Q, 1'b1, 200, "q_rise", ea);
        wait_sig(S_RISE, 1'b1, 200, "rise3", eb);
        chk_int("q_leads_e", eb - ea, 16);
        wait_sig(S_E14, 1'b1, 50, "e14_a", ea);
        wait_sig(S_E14, 1'b1, 50, "e14_b", eb);
        chk_int("en_14m_interval", eb - ea, 4);
        wait_sig(S_E358, 1'b1, 50, "e358_a", ea);
        chk_bit("en_3m58_with_14m", en_14m, 1'b1);
        wait_sig(S_E358, 1'b1, 50, "e358_b", eb);
        chk_int("en_3m58_interval", eb - ea, 16);

        // speed change requested mid-period
        wait_ph(10, 200, "ph10_slow");
        turbo = 1'b1;
        wait_sig(S_RISE, 1'b1, 200, "t_rise1", e1);
        chk_bit("tact_before_wrap", turbo_active, 1'b0);
        wait_sig(S_TACT, 1'b1, 200, "tact_rise", e_t);
        chk_int("tact_at_wrap", e_t - e1, 48);
        wait_sig(S_RISE, 1'b1, 200, "t_rise2", e2);
        wait_sig(S_RISE, 1'b1, 200, "t_rise3", e3);
        chk_int("transition_rise_interval", e2 - e1, 56);
        chk_int("fast_rise_interval", e3 - e2, 32);

        // lock loss in RUN
        wait_ph(20, 200, "ph20_fast");
        pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_bit("loss_periph_rst", periph_rst, 1'b1);
        chk_bit("loss_cpu_rst", cpu_rst, 1'b1);
        chk_bit("loss_cpu_e", cpu_e, 1'b0);
        chk_bit("loss_cpu_q", cpu_q, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_bit("loss_no_en_14m", en_14m, 1'b0);
            chk_bit("loss_no_en_3m58", en_3m58, 1'b0);
        end
        pll_locked = 1'b1;
        e_lock = edge_n + 1;
        wait_sig(S_PRST, 1'b0, 100, "relock_prst_fall", e_p);
        chk_int("relock_prst_delay", e_p - e_lock, LC + 2);
        wait_sig(S_CRST, 1'b0, 100, "relock_crst_fall", e_c);
        chk_int("relock_crst_gap", e_c - e_p, RG);
        chk_bit("tact_held_through_reset", turbo_active, 1'b1);

        // rst in the middle of PRST
        pll_locked = 1'b0;
        repeat (6) @(negedge clk);
        pll_locked = 1'b1;
        wait_sig(S_PRST, 1'b0, 100, "prst2_fall", e_p);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_bit("srst_periph_rst", periph_rst, 1'b1);
        chk_bit("srst_cpu_rst", cpu_rst, 1'b1);
        chk_bit("srst_en_14m", en_14m, 1'b0);
        chk_bit("srst_en_3m58", en_3m58, 1'b0);
        chk_bit("srst_cpu_e", cpu_e, 1'b0);
        chk_bit("srst_cpu_q", cpu_q, 1'b0);
        chk_bit("srst_turbo_active", turbo_active, 1'b0);
        rst = 1'b0;
        e_lock = edge_n + 1;
        wait_sig(S_PRST, 1'b0, 100, "post_rst_prst_fall", e_p);
        chk_int("post_rst_prst_delay", e_p - e_lock, LC + 2);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
